logic_unit_seq: RTL and testbench
=================================

# logic_unit_seq

Parametrised, multi-cycle bitwise logic unit that generalises the fixed 64-bit OR gate. It evaluates one of eight two-operand logic functions over WIDTH bits, processing SLICE bits per cycle, LSB slice first. A start/busy/done handshake lets the sequential datapath or control FSM trade area for latency. It sits alongside the ALU in the sequential processor.

## Interface
- WIDTH, 64: operand/result width; must be a multiple of SLICE.
- SLICE, 16: bits evaluated per cycle; K = WIDTH/SLICE cycles per operation.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  3  function select, latched at accept.
- a  in  WIDTH  operand A, latched at accept.
- b  in  WIDTH  operand B, latched at accept.
- busy  out  1  high while slices are being evaluated (RUN).
- done  out  1  one-cycle pulse: y and zero are final.
- y  out  WIDTH  result register.
- zero  out  1  high when the final y == 0; valid from done onward.

## Operation
- Op encoding: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 ANDN (a & ~b), 111 PASSA (a).
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: latch a, b, op into internal registers; clear y to 0; slice counter = 0; go to RUN.
- DONE with start=0: go to IDLE. IDLE with start=0: stay.
- RUN: each edge writes y[cnt*SLICE +: SLICE] = f(a_r, b_r) for that slice; cnt increments. When the slice with cnt = K-1 is written, go to DONE. zero is computed from the complete y at that same edge.
- start in RUN is ignored; it is not queued.
- a, b, op changes after accept have no effect on the running operation.
- y and zero hold their values in DONE and IDLE until the next accept. In RUN, y is partially updated and must not be consumed.
- Counter width: clog2(K), minimum 1 bit. The counter does not wrap past K-1.

## Timing
- Reset values: state IDLE, busy 0, done 0, y 0, zero 0, counter 0, latched operands 0.
- Reset asserted in any state, including mid-RUN: all of the above apply at that edge. The abandoned operation produces no done.
- Accept edge E0 → busy=1 from the cycle after E0.
- Slice i is written at edge E(i+1). Edge EK writes the last slice; from the cycle after EK, busy=0 and done=1.
- done lasts exactly one cycle unless start is accepted in DONE. In that case done is still one cycle, and busy rises the following cycle.
- Latency from accept to done is K cycles. Minimum start-to-start spacing is K+1 cycles (back-to-back accept in DONE).
- K=1 (SLICE=WIDTH): RUN lasts one cycle, and done follows the cycle after E1.

## Structure
- Package logic_pkg holds the op localparams (OP_AND..OP_PASSA) and the state encoding (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module logic_slice: combinational, parameter SLICE, ports a, b, op, y. It is instantiated once and fed the current slice selected by the counter.
- The FSM, counter, operand registers and result register live in logic_unit_seq.

## Test plan
All scenarios use WIDTH=64, SLICE=16 (K=4) unless noted otherwise.

1. **OR.** op=001, a=0xFFFFFFFFFFFFFFFF, b=0xAAAAAAAAAAAAAAAA, start for 1 cycle. Required: busy high for 4 cycles, then done for 1 cycle, y=0xFFFFFFFFFFFFFFFF, zero=0.
2. **XOR to zero.** op=010, a=b=0xFFFFFFFFFFFFFFFF. Required: y=0 and zero=1 at done. Then op=001 with a=0x1, b=0x0: y=0x1, zero=0.
3. **ANDN.** op=110, a=0xDB6DB6DB6DB6DB6D, b=0xAAAAAAAAAAAAAAAA. Required: y=0x5145145145145145. Then op=111 with b=0: y=a.
4. **Operand isolation.** Accept op=000 with a=b=0xFFFFFFFFFFFFFFFF. Two cycles later, drive start=1, a=0, op=001. Required: second request ignored, y=0xFFFFFFFFFFFFFFFF at done, exactly one done pulse. Then start held high through DONE: new accept occurs in DONE, with spacing of 5 cycles.
5. **Reset mid-RUN.** Assert reset in the 2nd RUN cycle. Required: the next cycle shows busy=0, done=0, y=0, and no done ever arrives for that operation. A subsequent op=011 with a=b=0 gives y=0xFFFFFFFFFFFFFFFF.
6. **Single-cycle config.** WIDTH=32, SLICE=32: op=011, a=b=0. Required: busy for 1 cycle, then done, y=0xFFFFFFFF.

Source files
------------

// File: rtl/logic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_pkg
// Description : Shared op-select codes and FSM state encoding for the
//               sequential bitwise logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_pkg;

    // Function-select codes for the two-operand logic functions
    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOR   = 3'b011;
    localparam logic [2:0] OP_NAND  = 3'b100;
    localparam logic [2:0] OP_XNOR  = 3'b101;
    localparam logic [2:0] OP_ANDN  = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/logic_slice.sv
`default_nettype none
// ============================================================================
// Module      : logic_slice
// Description : Combinational SLICE-bit evaluator of the eight two-operand
//               logic functions selected by op.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_slice
    import logic_pkg::*;
#(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [2:0]       op,
    output logic [SLICE-1:0] y
);

    // Bitwise function of the current operand slices
    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOR:   y = ~(a | b);
            OP_NAND:  y = ~(a & b);
            OP_XNOR:  y = ~(a ^ b);
            OP_ANDN:  y = a & ~b;
            OP_PASSA: y = a;
            default:  y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_seq
// Description : Multi-cycle bitwise logic unit. Evaluates one of eight logic
//               functions over WIDTH bits, SLICE bits per cycle, LSB slice
//               first, behind a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_seq
    import logic_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    localparam int c_num_slices = WIDTH / SLICE;
    localparam int c_cnt_w      = (c_num_slices > 1) ? $clog2(c_num_slices) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_num_slices - 1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;

    int unsigned        w_base;
    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_y_slice;
    logic [WIDTH-1:0]   w_y_next;

    // Select the operand slices addressed by the counter
    always_comb begin
        w_base    = 32'(r_cnt) * SLICE;
        w_a_slice = r_a[w_base +: SLICE];
        w_b_slice = r_b[w_base +: SLICE];
    end

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a  (w_a_slice),
        .b  (w_b_slice),
        .op (r_op),
        .y  (w_y_slice)
    );

    // Result with the current slice merged in; zero flag is taken from this
    // so it reflects the complete word on the final slice edge
    always_comb begin
        w_y_next                 = y;
        w_y_next[w_base +: SLICE] = w_y_slice;
    end

    // Controller: accept, per-slice evaluation, one-cycle done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            y       <= '0;
            zero    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_cnt   <= '0;
                        y       <= '0;
                        zero    <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    y <= w_y_next;
                    if (r_cnt == c_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        zero    <= (w_y_next == '0);
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_seq
// Description : Scoreboard bench for logic_unit_seq. A driver issues directed
//               and random requests and records expected results/timing from
//               a word-level model; a negedge monitor compares busy/done each
//               cycle and pops results whenever done is seen. A second
//               single-slice instance is exercised directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_seq;

    localparam int WIDTH = 64;
    localparam int SLICE = 16;
    localparam int K     = WIDTH / SLICE;
    localparam int NEVER = 32'h7fff_ffff;

    logic             clk = 1'b0;
    logic             reset, start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, zero;
    logic [WIDTH-1:0] y;

    logic             reset2, start2;
    logic [2:0]       op2;
    logic [31:0]      a2, b2;
    logic             busy2, done2, zero2;
    logic [31:0]      y2;

    logic_unit_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .zero(zero)
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(32)) dut1 (
        .clk(clk), .reset(reset2), .start(start2), .op(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .y(y2), .zero(zero2)
    );

    initial forever #5 clk = ~clk;

    int n = 0;
    always @(posedge clk) n <= n + 1;

    typedef struct { int e; int kill; } op_rec_t;
    typedef struct { int e; logic [63:0] y; logic z; } exp_t;
    op_rec_t ops[$];
    exp_t    exp_q[$];
    bit      rst_at[int];
    int      next_free = 0;
    int      total = 0;
    int      bad   = 0;

    function automatic logic [63:0] ref_fn(input logic [2:0] o, input logic [63:0] x, input logic [63:0] w);
        case (o)
            3'd0: return x & w;
            3'd1: return x | w;
            3'd2: return x ^ w;
            3'd3: return ~(x | w);
            3'd4: return ~(x & w);
            3'd5: return ~(x ^ w);
            3'd6: return x & ~w;
            default: return x;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s @edge %0d: got %h want %h", name, n, act, req);
        end
    endtask

    // Drive one cycle of inputs (called at posedge+#1) and update the model
    // for the edge these inputs will be sampled on.
    task automatic step(input logic s, input logic [2:0] o, input logic [63:0] x,
                        input logic [63:0] w, input logic r);
        int e;
        logic [63:0] yy;
        e = n + 1;
        reset = r; start = s; op = o; a = x; b = w;
        if (r) begin
            rst_at[e] = 1'b1;
            foreach (ops[i])
                if (ops[i].kill == NEVER && ops[i].e + K >= e) ops[i].kill = e;
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].e >= e) exp_q.delete(i);
            next_free = e + 1;
        end else if (s && e >= next_free) begin
            yy = ref_fn(o, x, w);
            ops.push_back('{e: e, kill: NEVER});
            exp_q.push_back('{e: e + K, y: yy, z: (yy == 64'd0)});
            next_free = e + K + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int c);
        repeat (c) step(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    endtask

    // Monitor: per-cycle busy/done timing and scoreboard pops on done
    always @(negedge clk) begin : p_mon
        logic eb, ed;
        exp_t ex;
        if (n > 0) begin
            eb = 1'b0;
            ed = 1'b0;
            foreach (ops[i]) begin
                if (n < ops[i].kill && n >= ops[i].e && n <= ops[i].e + K - 1) eb = 1'b1;
                if (n < ops[i].kill && n == ops[i].e + K) ed = 1'b1;
            end
            chk("busy", busy, eb);
            chk("done", done, ed);
            if (rst_at.exists(n)) begin
                chk("reset_y", y, 64'd0);
                chk("reset_zero", zero, 1'b0);
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 1'b1, 1'b0);
                end else begin
                    ex = exp_q.pop_front();
                    chk("done_edge", n, ex.e);
                    chk("result_y", y, ex.y);
                    chk("result_zero", zero, ex.z);
                end
            end
        end
    end

    task automatic run_k1(input logic [2:0] o, input logic [31:0] x, input logic [31:0] w);
        logic [63:0] r64;
        logic [31:0] r32;
        r64 = ref_fn(o, {32'd0, x}, {32'd0, w});
        r32 = r64[31:0];
        start2 = 1'b1; op2 = o; a2 = x; b2 = w;
        @(posedge clk); #1;
        start2 = 1'b0; a2 = ~x; op2 = ~o;
        chk("k1_busy_run", busy2, 1'b1);
        chk("k1_done_run", done2, 1'b0);
        @(posedge clk); #1;
        chk("k1_busy_done", busy2, 1'b0);
        chk("k1_done", done2, 1'b1);
        chk("k1_y", y2, r32);
        chk("k1_zero", zero2, (r32 == 32'd0));
        @(posedge clk); #1;
        chk("k1_done_pulse", done2, 1'b0);
        chk("k1_y_hold", y2, r32);
    endtask

    initial begin
        logic [63:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        reset2 = 1'b1; start2 = 1'b0; op2 = 3'd0; a2 = '0; b2 = '0;

        step(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        step(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        idle(2);

        // OR
        step(1'b1, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        idle(K + 2);
        // XOR to zero, then OR of 1
        step(1'b1, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        idle(K + 2);
        step(1'b1, 3'b001, 64'h1, 64'h0, 1'b0);
        idle(K + 2);
        // ANDN, then PASSA
        step(1'b1, 3'b110, 64'hDB6D_B6DB_6DB6_DB6D, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        idle(K + 2);
        step(1'b1, 3'b111, 64'hDB6D_B6DB_6DB6_DB6D, 64'h0, 1'b0);
        idle(K + 2);
        // Operand isolation, ignored start in RUN, back-to-back accept in DONE
        step(1'b1, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step(1'b0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step(1'b1, 3'b001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step(1'b1, 3'b001, 64'h0, 64'h0, 1'b0);
        step(1'b1, 3'b001, 64'h0, 64'h0, 1'b0);
        step(1'b1, 3'b001, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1'b0);
        idle(K + 2);
        // Reset in the second RUN cycle, then NOR of zeros
        step(1'b1, 3'b010, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0000_FFFF_0001, 1'b0);
        step(1'b0, 3'b000, 64'h0, 64'h0, 1'b0);
        step(1'b0, 3'b000, 64'h0, 64'h0, 1'b1);
        idle(K + 2);
        step(1'b1, 3'b011, 64'h0, 64'h0, 1'b0);
        idle(K + 2);

        // Random traffic with occasional resets
        repeat (80) begin
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rb,
                 ($urandom_range(0, 24) == 0));
        end
        idle(K + 3);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Single-slice configuration
        chk("k1_reset_busy", busy2, 1'b0);
        chk("k1_reset_y", y2, 32'd0);
        reset2 = 1'b0;
        @(posedge clk); #1;
        run_k1(3'b011, 32'h0, 32'h0);
        repeat (6) run_k1(3'($urandom_range(0, 7)), $urandom, $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
